decimal_entry_to_binary: RTL

- Converts a stream of decimal digits (keypad/switch entry, most-significant digit first) into a 16-bit unsigned binary value.
- Feeds order price/quantity fields into the book logic. It is the input-side counterpart of the binary-to-5-digit seven-segment display path.
- Supports backspace (sequential divide-by-10), clear and commit. The running value is exposed so the display path can echo the entry live.

---
 rtl/decimal_entry_to_binary.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/decimal_entry_to_binary.sv
// Decimal keypad entry to unsigned binary: MSB-first digit accumulation,
// backspace by sequential restoring divide-by-10, clear, and commit.
//
// state | meaning
// ENTRY | idle, accepting digits / clear / commit / backspace
// DIV   | restoring divide of entry_val by 10, one quotient bit per cycle
module decimal_entry_to_binary #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5,
  parameter int DIV_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       digit_in,
  input  logic             digit_valid,
  output logic             digit_ready,
  input  logic             backspace,
  input  logic             clear,
  input  logic             commit,
  output logic [WIDTH-1:0] entry_val,
  output logic [2:0]       digit_count,
  output logic [WIDTH-1:0] val_out,
  output logic             val_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic {ENTRY, DIV} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] entry_val_n, val_out_n;
  logic [2:0]       digit_count_n;
  logic             val_valid_n, overflow_n;
  logic [WIDTH-1:0] div_q, div_q_n;
  logic [3:0]       div_rem, div_rem_n;
  logic [CW-1:0]    div_cnt, div_cnt_n;

  logic [WIDTH+3:0] ext_val, next_val;
  logic             too_big, full;
  logic [4:0]       trial;
  logic             trial_ge;
  logic [WIDTH-1:0] q_step;
  logic [3:0]       rem_step;

  // entry*10 + d via shift-add, with 4 guard bits to catch range overflow
  assign ext_val  = {4'b0000, entry_val};
  assign next_val = (ext_val << 3) + (ext_val << 1) + {{WIDTH{1'b0}}, digit_in};
  assign too_big  = |next_val[WIDTH+3:WIDTH];
  assign full     = (digit_count == 3'(MAX_DIGITS));

  // trial is the remainder plus its 1-bit extension after shifting in the next dividend bit
  assign trial    = {div_rem, div_q[WIDTH-1]};
  assign trial_ge = (trial >= 5'd10);
  assign rem_step = 4'(trial_ge ? (trial - 5'd10) : trial);
  assign q_step   = {div_q[WIDTH-2:0], trial_ge};

  assign digit_ready = (state == ENTRY);
  assign busy        = (state == DIV);

  always_comb begin
    state_n       = state;
    entry_val_n   = entry_val;
    digit_count_n = digit_count;
    val_out_n     = val_out;
    val_valid_n   = 1'b0;
    overflow_n    = overflow;
    div_q_n       = div_q;
    div_rem_n     = div_rem;
    div_cnt_n     = div_cnt;
    case (state)
      ENTRY: begin
        if (clear) begin
          entry_val_n   = '0;
          digit_count_n = '0;
          overflow_n    = 1'b0;
        end else if (commit) begin
          val_out_n     = entry_val;
          val_valid_n   = 1'b1;
          entry_val_n   = '0;
          digit_count_n = '0;
          overflow_n    = 1'b0;
        end else if (backspace) begin
          if (digit_count != 3'd0) begin
            state_n   = DIV;
            div_q_n   = entry_val;
            div_rem_n = '0;
            div_cnt_n = CW'(DIV_CYCLES - 1);
          end
        end else if (digit_valid && (digit_in <= 4'd9)) begin
          if (full || too_big) begin
            overflow_n = 1'b1;
          end else begin
            entry_val_n   = next_val[WIDTH-1:0];
            digit_count_n = digit_count + 3'd1;
          end
        end
      end
      DIV: begin
        if (clear) begin
          state_n       = ENTRY;
          entry_val_n   = '0;
          digit_count_n = '0;
          overflow_n    = 1'b0;
        end else begin
          div_q_n   = q_step;
          div_rem_n = rem_step;
          if (div_cnt == '0) begin
            state_n       = ENTRY;
            entry_val_n   = q_step;
            digit_count_n = digit_count - 3'd1;
          end else begin
            div_cnt_n = div_cnt - CW'(1);
          end
        end
      end
      default: state_n = ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ENTRY;
      entry_val   <= '0;
      digit_count <= '0;
      val_out     <= '0;
      val_valid   <= 1'b0;
      overflow    <= 1'b0;
      div_q       <= '0;
      div_rem     <= '0;
      div_cnt     <= '0;
    end else begin
      state       <= state_n;
      entry_val   <= entry_val_n;
      digit_count <= digit_count_n;
      val_out     <= val_out_n;
      val_valid   <= val_valid_n;
      overflow    <= overflow_n;
      div_q       <= div_q_n;
      div_rem     <= div_rem_n;
      div_cnt     <= div_cnt_n;
    end
  end

endmodule
